// File: rtl/bool_sweep_checker_pkg.sv
// Shared types and constants for the exhaustive Boolean truth-table sweep checker.
package bool_sweep_pkg;

  localparam int SETTLE_W = 4;
  localparam int N_IN_MAX = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t HOLD   = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t FIN    = 2'd3;

endpackage

// File: rtl/bool_sweep_checker.sv
// Walks every input code, samples resp after a settle window and scores it against EXPECTED.
// Optional SWEEP_CAPTURE_EN adds the captured port holding the sampled truth table.
module bool_sweep_checker
  import bool_sweep_pkg::*;
#(
  parameter int                N_IN     = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = '0,
  parameter int                SETTLE   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [N_IN-1:0]    stim,
  input  logic               resp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      err_cnt,
  output logic               first_err_vld,
  output logic [N_IN-1:0]    first_err_idx
`ifdef SWEEP_CAPTURE_EN
  ,
  output logic [2**N_IN-1:0] captured
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);
  localparam logic [N_IN-1:0]     LAST     = {N_IN{1'b1}};

  state_t               state_q, state_d;
  logic [N_IN-1:0]      stim_q, stim_d;
  logic [SETTLE_W-1:0]  cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [N_IN:0]        err_q, err_d;
  logic                 fvld_q, fvld_d;
  logic [N_IN-1:0]      fidx_q, fidx_d;
`ifdef SWEEP_CAPTURE_EN
  logic [2**N_IN-1:0]   cap_q, cap_d;
`endif

  logic mismatch;
  assign mismatch = resp != EXPECTED[stim_q];

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fidx_d  = fidx_q;
`ifdef SWEEP_CAPTURE_EN
    cap_d   = cap_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = HOLD;
        stim_d  = '0;
        cnt_d   = SETTLE_L;
        busy_d  = 1'b1;
        pass_d  = 1'b0;
        err_d   = '0;
        fvld_d  = 1'b0;
        fidx_d  = '0;
`ifdef SWEEP_CAPTURE_EN
        cap_d   = '0;
`endif
      end
      HOLD: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!fvld_q) begin
            fvld_d = 1'b1;
            fidx_d = stim_q;
          end
        end
`ifdef SWEEP_CAPTURE_EN
        cap_d[stim_q] = resp;
`endif
        // Last code: pass is judged on the count that includes this sample.
        if (stim_q == LAST) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = SETTLE_L;
          state_d = HOLD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fidx_q  <= '0;
`ifdef SWEEP_CAPTURE_EN
      cap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fidx_q  <= fidx_d;
`ifdef SWEEP_CAPTURE_EN
      cap_q   <= cap_d;
`endif
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_vld = fvld_q;
  assign first_err_idx = fidx_q;
`ifdef SWEEP_CAPTURE_EN
  assign captured      = cap_q;
`endif

endmodule
